// File: rtl/periodic_sign_quantizer.sv
// Periodic I/Q accumulator: folds REP repetitions of a PERIOD-sample training
// sequence into saturating cells and reports one sign word per rail per block.

module psq_cell #(
   parameter int DW = 8,
   parameter int AW = 12
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [DW-1:0] smp_r_i,
   input  logic [DW-1:0] smp_i_i,
   output logic          sgn_r_o,
   output logic          sgn_i_o,
   output logic          sat_o
);

   logic [AW-1:0] cr_q, ci_q;
   logic [AW-1:0] sum_r, sum_i;
   logic          ovf_r, ovf_i;

   // Returns {overflow, clamped sum}; one guard bit detects overflow.
   function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [DW-1:0] b);
      logic [AW:0] w;
      w = {a[AW-1], a} + {{(AW+1-DW){b[DW-1]}}, b};
      if (w[AW] != w[AW-1])
         sat_add = {1'b1, w[AW], {(AW-1){~w[AW]}}};
      else
         sat_add = {1'b0, w[AW-1:0]};
   endfunction

   assign {ovf_r, sum_r} = sat_add(cr_q, smp_r_i);
   assign {ovf_i, sum_i} = sat_add(ci_q, smp_i_i);

   always_ff @(posedge Clk) begin
      if (Rst || clr_i) begin
         cr_q <= '0;
         ci_q <= '0;
      end else if (en_i) begin
         cr_q <= sum_r;
         ci_q <= sum_i;
      end
   end

   // Sign seen by the block-end capture includes an update landing this cycle.
   assign sgn_r_o = en_i ? sum_r[AW-1] : cr_q[AW-1];
   assign sgn_i_o = en_i ? sum_i[AW-1] : ci_q[AW-1];
   assign sat_o   = en_i & (ovf_r | ovf_i);

endmodule

module periodic_sign_quantizer #(
   parameter int DW     = 8,
   parameter int AW     = 12,
   parameter int PERIOD = 16,
   parameter int REP_W  = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              inEn,
   input  logic [DW-1:0]     bitInR,
   input  logic [DW-1:0]     bitInI,
   input  logic [REP_W-1:0]  cfgReps,
   output logic              outValid,
   output logic [PERIOD-1:0] outReal,
   output logic [PERIOD-1:0] outImag,
   output logic              satFlag
);

   localparam int IW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              en_q;
   logic [DW-1:0]     smp_r_q, smp_i_q;
   logic [IW-1:0]     idx_q, idx_d;
   logic [REP_W-1:0]  rep_q, rep_d, reps_q, reps_d;
   logic              sat_q, sat_d;
   logic [1:0]        vld_pipe_q;
   logic [PERIOD-1:0] pend_r_q, pend_i_q, out_r_q, out_i_q;
   logic              pend_sat_q, out_sat_q;

   logic [PERIOD-1:0] cell_en, sgn_r, sgn_i, cell_sat;
   logic              acc, abort, last_idx, blk_end, clr, start;

   assign acc      = (state_q == S_ACC) && en_q;
   assign abort    = (state_q == S_ACC) && !en_q;
   assign last_idx = (idx_q == IW'(PERIOD-1));
   assign blk_end  = acc && last_idx && (rep_q == reps_q - REP_W'(1));
   assign clr      = abort || blk_end;
   // A new block begins from idle, after an abort, or back-to-back at block end.
   assign start    = inEn && ((state_q == S_IDLE) || clr);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      reps_d  = reps_q;
      sat_d   = sat_q;
      if (clr || state_q == S_IDLE) begin
         idx_d   = '0;
         rep_d   = '0;
         sat_d   = 1'b0;
         state_d = inEn ? S_ACC : S_IDLE;
      end else if (acc) begin
         sat_d = sat_q | (|cell_sat);
         if (last_idx) begin
            idx_d = '0;
            rep_d = rep_q + REP_W'(1);
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
      if (start)
         reps_d = (cfgReps == '0) ? REP_W'(1) : cfgReps;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         smp_r_q <= '0;
         smp_i_q <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         reps_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= inEn;
         smp_r_q <= bitInR;
         smp_i_q <= bitInI;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         reps_q  <= reps_d;
         sat_q   <= sat_d;
      end
   end

   for (genvar k = 0; k < PERIOD; k++) begin : g_cell
      assign cell_en[k] = acc && (idx_q == IW'(k));
      psq_cell #(.DW(DW), .AW(AW)) u_cell (
         .Clk     (Clk),
         .Rst     (Rst),
         .clr_i   (clr),
         .en_i    (cell_en[k]),
         .smp_r_i (smp_r_q),
         .smp_i_i (smp_i_q),
         .sgn_r_o (sgn_r[k]),
         .sgn_i_o (sgn_i[k]),
         .sat_o   (cell_sat[k])
      );
   end

   // Block-end signs are staged once so the pulse lands one cycle after the update.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         vld_pipe_q <= '0;
         pend_r_q   <= '0;
         pend_i_q   <= '0;
         pend_sat_q <= 1'b0;
         out_r_q    <= '0;
         out_i_q    <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[0], blk_end};
         if (blk_end) begin
            pend_r_q   <= sgn_r;
            pend_i_q   <= sgn_i;
            pend_sat_q <= sat_q | (|cell_sat);
         end
         if (vld_pipe_q[0]) begin
            out_r_q   <= pend_r_q;
            out_i_q   <= pend_i_q;
            out_sat_q <= pend_sat_q;
         end
      end
   end

   assign outValid = vld_pipe_q[1];
   assign outReal  = out_r_q;
   assign outImag  = out_i_q;
   assign satFlag  = out_sat_q;

endmodule

// File: tb/tb_periodic_sign_quantizer.sv
// Scoreboard bench: two instances (default AW and AW=10) share stimulus;
// expected blocks are queued at issue time and popped on each outValid.

module tb_periodic_sign_quantizer;

   logic        Clk = 1'b0;
   logic        Rst, inEn;
   logic [7:0]  bitInR, bitInI;
   logic [3:0]  cfgReps;
   logic        v0, v1, s0, s1;
   logic [15:0] r0, i0, r1, i1;

   always #5 Clk = ~Clk;

   periodic_sign_quantizer u_dut0 (
      .Clk(Clk), .Rst(Rst), .inEn(inEn), .bitInR(bitInR), .bitInI(bitInI),
      .cfgReps(cfgReps), .outValid(v0), .outReal(r0), .outImag(i0), .satFlag(s0));

   periodic_sign_quantizer #(.AW(10)) u_dut1 (
      .Clk(Clk), .Rst(Rst), .inEn(inEn), .bitInR(bitInR), .bitInI(bitInI),
      .cfgReps(cfgReps), .outValid(v1), .outReal(r1), .outImag(i1), .satFlag(s1));

   typedef struct {
      logic [15:0] r;
      logic [15:0] im;
      logic        s;
      int          cyc;
   } exp_t;

   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int   cyc = 0;
   int   checks = 0, errors = 0;
   int   last_cyc = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge Clk) begin
      if (v0 === 1'b1) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut0_unexpected_pulse actual=pulse expected=none (cyc %0d)", cyc);
         end else begin
            e0 = q0.pop_front();
            chk("dut0_cyc", cyc, e0.cyc);
            chk("dut0_real", r0, e0.r);
            chk("dut0_imag", i0, e0.im);
            chk("dut0_sat", s0, e0.s);
         end
      end
      if (v1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_unexpected_pulse actual=pulse expected=none (cyc %0d)", cyc);
         end else begin
            e1 = q1.pop_front();
            chk("dut1_cyc", cyc, e1.cyc);
            chk("dut1_real", r1, e1.r);
            chk("dut1_imag", i1, e1.im);
            chk("dut1_sat", s1, e1.s);
         end
      end
   end

   task automatic feed(input int r, input int im);
      bitInR   = 8'(r);
      bitInI   = 8'(im);
      inEn     = 1'b1;
      last_cyc = cyc;
      @(posedge Clk); #1;
   endtask

   task automatic idle(input int n);
      inEn = 1'b0;
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   task automatic expect_blk(input logic [15:0] r, input logic [15:0] im,
                             input logic sat0, input logic sat1);
      exp_t e;
      e.r = r; e.im = im; e.cyc = last_cyc + 3;
      e.s = sat0; q0.push_back(e);
      e.s = sat1; q1.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_v0"}, v0, 0);  chk({tag, "_r0"}, r0, 0);
      chk({tag, "_i0"}, i0, 0);  chk({tag, "_s0"}, s0, 0);
      chk({tag, "_v1"}, v1, 0);  chk({tag, "_r1"}, r1, 0);
      chk({tag, "_i1"}, i1, 0);  chk({tag, "_s1"}, s1, 0);
   endtask

   function automatic int t3r(input int rep, input int k);
      case (k)
         0:  t3r = (rep == 0) ?  7 : -8;
         1:  t3r = (rep == 0) ?  8 : -8;
         2:  t3r = (rep == 0) ?  3 : -5;
         15: t3r = (rep == 0) ? -1 :  1;
         default: t3r = 0;
      endcase
   endfunction

   initial begin
      Rst = 1'b1; inEn = 1'b0; bitInR = '0; bitInI = '0; cfgReps = 4'd1;
      repeat (2) @(posedge Clk);
      #1;
      chk_zero("reset");
      Rst = 1'b0;
      idle(2);

      // constant block: real non-negative, imag all negative
      cfgReps = 4'd1;
      for (int k = 0; k < 16; k++) feed(5, -3);
      expect_blk(16'h0000, 16'hFFFF, 1'b0, 1'b0);
      idle(4);

      // four repetitions, alternating real sign per position
      cfgReps = 4'd4;
      for (int n = 0; n < 64; n++) feed((n % 2 == 0) ? 10 : -10, 1);
      expect_blk(16'hAAAA, 16'h0000, 1'b0, 1'b0);
      idle(4);

      // near-zero sums: -1 -> 1, 0 -> 0
      cfgReps = 4'd2;
      for (int rep = 0; rep < 2; rep++)
         for (int k = 0; k < 16; k++) feed(t3r(rep, k), (k < 8) ? -1 : 1);
      expect_blk(16'h0005, 16'h00FF, 1'b0, 1'b0);
      idle(4);

      // saturation in the narrow instance only, both polarities
      cfgReps = 4'd8;
      for (int n = 0; n < 128; n++) feed(127, -128);
      expect_blk(16'h0000, 16'hFFFF, 1'b0, 1'b1);
      idle(4);

      // clean block clears the sticky flag
      cfgReps = 4'd1;
      for (int k = 0; k < 16; k++) feed(-2, 2);
      expect_blk(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      idle(4);

      // cfgReps=0 behaves as one repetition
      cfgReps = 4'd0;
      for (int k = 0; k < 16; k++) feed((k < 8) ? -4 : 4, (k % 4 == 0) ? -1 : 1);
      expect_blk(16'h00FF, 16'h1111, 1'b0, 1'b0);
      idle(4);

      // aborted burst: outputs hold, no pulse
      cfgReps = 4'd2;
      for (int n = 0; n < 10; n++) feed(3, 3);
      idle(3);
      chk("hold_r0", r0, 16'h00FF); chk("hold_i0", i0, 16'h1111);
      chk("hold_r1", r1, 16'h00FF); chk("hold_i1", i1, 16'h1111);
      // mid-block cfgReps change must be ignored
      for (int n = 0; n < 32; n++) begin
         feed(-1, 1);
         if (n == 0) cfgReps = 4'd1;
      end
      expect_blk(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      idle(4);

      // three back-to-back blocks, then reset inside the fourth
      cfgReps = 4'd1;
      for (int k = 0; k < 16; k++) feed(k, -k);
      expect_blk(16'h0000, 16'hFFFE, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) feed(k - 8, 8 - k);
      expect_blk(16'h00FF, 16'hFE00, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) feed((k % 2 == 1) ? -1 : 0, (k == 15) ? -5 : 5);
      expect_blk(16'hAAAA, 16'h8000, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) feed(-7, -7);
      Rst = 1'b1; inEn = 1'b0;
      @(posedge Clk); #1;
      chk_zero("midrst");
      Rst = 1'b0;
      idle(8);

      chk("dut0_missing_pulses", q0.size(), 0);
      chk("dut1_missing_pulses", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
